// File: rtl/mux_gate_sweeper.sv
// Self-check sweeper for gates built only from 2:1 muxes.
// Sweeps operand pairs, compares against native operators, counts and captures failures.
module mux_gate_sweeper #(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [2:0]     mode_i,
  input  logic           fault_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [2*W+2:0] fail_cnt_o,
  output logic           first_fail_vld_o,
  output logic [2:0]     first_fail_op_o,
  output logic [W-1:0]   first_fail_a_o,
  output logic [W-1:0]   first_fail_b_o
);

  localparam int VW = 2 * W;
  localparam int CW = 2 * W + 3;
  localparam logic [VW-1:0] VONE = VW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [2:0] OP_ALL = 3'd7;
  localparam logic [2:0] OP_LAST = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          all_q, all_d;
  logic [2:0]    op_q, op_d;
  logic [VW-1:0] vec_q, vec_d;
  logic          issue, accept, to_done;

  logic          s1_vld_q;
  logic [2:0]    s1_op_q;
  logic [W-1:0]  s1_a_q, s1_b_q;
  logic [W-1:0]  s1_exp_q, s1_act_q;

  logic [CW-1:0] cnt_q;
  logic          pass_q;
  logic          ffv_q;
  logic [2:0]    ffop_q;
  logic [W-1:0]  ffa_q, ffb_q;

  logic [W-1:0]  a_iss, b_iss;
  logic [W-1:0]  exp_v, act_raw, act_v;

  function automatic logic mux2(input logic d0, input logic d1,
                                input logic sel);
    return sel ? d1 : d0;
  endfunction

  function automatic logic inv1(input logic x);
    return mux2(1'b1, 1'b0, x);
  endfunction

  function automatic logic gate_bit(input logic [2:0] op,
                                    input logic x, input logic y);
    logic r_and, r_or, r_xor, r_xnor, r;
    r_and  = mux2(1'b0, x, y);
    r_or   = mux2(x, 1'b1, y);
    r_xor  = mux2(x, inv1(x), y);
    r_xnor = mux2(inv1(x), x, y);
    unique case (op)
      3'd0:    r = inv1(x);
      3'd1:    r = r_and;
      3'd2:    r = r_or;
      3'd3:    r = r_xor;
      3'd4:    r = inv1(r_and);
      3'd5:    r = inv1(r_or);
      3'd6:    r = r_xnor;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] gate_ref(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    unique case (op)
      3'd0:    r = ~a;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign a_iss = vec_q[VW-1:W];
  assign b_iss = vec_q[W-1:0];

  always_comb begin
    exp_v   = gate_ref(op_q, a_iss, b_iss);
    act_raw = '0;
    for (int i = 0; i < W; i++) begin
      act_raw[i] = gate_bit(op_q, a_iss[i], b_iss[i]);
    end
    act_v    = act_raw;
    // Fault injection flips bit 0 through a mux as well
    act_v[0] = mux2(act_raw[0], inv1(act_raw[0]), fault_i);
  end

  always_comb begin
    state_d = state_q;
    all_d   = all_q;
    op_d    = op_q;
    vec_d   = vec_q;
    issue   = 1'b0;
    accept  = 1'b0;
    to_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = S_SWEEP;
          all_d   = (mode_i == OP_ALL);
          op_d    = (mode_i == OP_ALL) ? 3'd0 : mode_i;
          vec_d   = '0;
        end
      end
      S_SWEEP: begin
        issue = 1'b1;
        vec_d = vec_q + VONE;
        if (vec_q == '1) begin
          if (!all_q || op_q == OP_LAST) begin
            state_d = S_DRAIN1;
          end else begin
            op_d = op_q + 3'd1;
          end
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: begin
        state_d = S_DONE;
        to_done = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      all_q   <= 1'b0;
      op_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      all_q   <= all_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_exp_q <= '0;
      s1_act_q <= '0;
    end else begin
      s1_vld_q <= issue;
      if (issue) begin
        s1_op_q  <= op_q;
        s1_a_q   <= a_iss;
        s1_b_q   <= b_iss;
        s1_exp_q <= exp_v;
        s1_act_q <= act_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pass_q <= 1'b0;
      ffv_q  <= 1'b0;
      ffop_q <= '0;
      ffa_q  <= '0;
      ffb_q  <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      pass_q <= 1'b0;
      ffv_q  <= 1'b0;
      ffop_q <= '0;
      ffa_q  <= '0;
      ffb_q  <= '0;
    end else begin
      if (s1_vld_q && (s1_exp_q != s1_act_q)) begin
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CONE;
        end
        if (!ffv_q) begin
          ffv_q  <= 1'b1;
          ffop_q <= s1_op_q;
          ffa_q  <= s1_a_q;
          ffb_q  <= s1_b_q;
        end
      end
      if (to_done) begin
        pass_q <= (cnt_q == '0);
      end
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign fail_cnt_o       = cnt_q;
  assign first_fail_vld_o = ffv_q;
  assign first_fail_op_o  = ffop_q;
  assign first_fail_a_o   = ffa_q;
  assign first_fail_b_o   = ffb_q;

endmodule

// File: tb/tb_mux_gate_sweeper.sv
// Bench for mux_gate_sweeper: W=2 and W=3 instances, sweep-level model
// checked every cycle plus literal expectations per scenario.
module tb_mux_gate_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       fault_i = 1'b0;
  logic [2:0] mode_i = 3'd0;
  logic       wsel = 1'b0;

  always #5 clk = ~clk;

  logic       a_busy, a_done, a_pass, a_ffv;
  logic [6:0] a_cnt;
  logic [2:0] a_ffop;
  logic [1:0] a_ffa, a_ffb;

  logic       b_busy, b_done, b_pass, b_ffv;
  logic [8:0] b_cnt;
  logic [2:0] b_ffop;
  logic [2:0] b_ffa, b_ffb;

  mux_gate_sweeper #(.W(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .mode_i(mode_i), .fault_i(fault_i),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
    .fail_cnt_o(a_cnt), .first_fail_vld_o(a_ffv),
    .first_fail_op_o(a_ffop), .first_fail_a_o(a_ffa),
    .first_fail_b_o(a_ffb)
  );

  mux_gate_sweeper #(.W(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .mode_i(mode_i), .fault_i(fault_i),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
    .fail_cnt_o(b_cnt), .first_fail_vld_o(b_ffv),
    .first_fail_op_o(b_ffop), .first_fail_a_o(b_ffa),
    .first_fail_b_o(b_ffb)
  );

  int o_busy, o_done, o_pass, o_ffv, o_cnt, o_ffop, o_ffa, o_ffb;

  always_comb begin
    o_busy = wsel ? int'(b_busy) : int'(a_busy);
    o_done = wsel ? int'(b_done) : int'(a_done);
    o_pass = wsel ? int'(b_pass) : int'(a_pass);
    o_ffv  = wsel ? int'(b_ffv)  : int'(a_ffv);
    o_cnt  = wsel ? int'(b_cnt)  : int'(a_cnt);
    o_ffop = wsel ? int'(b_ffop) : int'(a_ffop);
    o_ffa  = wsel ? int'(b_ffa)  : int'(a_ffa);
    o_ffb  = wsel ? int'(b_ffb)  : int'(a_ffb);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  int cyc = 0;
  bit m_run = 0;
  bit m_all = 0;
  int m_t, m_n, m_w, m_mode;
  int m_cnt = 0, m_pass = 0, m_ffv = 0;
  int m_ffop = 0, m_ffa = 0, m_ffb = 0;
  int m_k, m_per, m_v, m_op;
  int done_n = 0, done_cyc = -1, first_done = -1;
  int busy_n = 0, busy_first = -1;
  int cap_pass, cap_cnt, cap_ffv, cap_ffop, cap_ffa, cap_ffb;

  task automatic chk_results(input string tag);
    chk({tag, "_pass"}, o_pass, m_pass);
    chk({tag, "_cnt"}, o_cnt, m_cnt);
    chk({tag, "_ffv"}, o_ffv, m_ffv);
    chk({tag, "_ffop"}, o_ffop, m_ffop);
    chk({tag, "_ffa"}, o_ffa, m_ffa);
    chk({tag, "_ffb"}, o_ffb, m_ffb);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_pass = 0; m_ffv = 0;
      m_ffop = 0; m_ffa = 0; m_ffb = 0;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk_results("rst");
    end else begin
      if (o_busy != 0) begin
        busy_n++;
        if (busy_first < 0) busy_first = cyc;
      end
      if (o_done != 0) begin
        done_n++;
        done_cyc = cyc;
        if (first_done < 0) first_done = cyc;
        cap_pass = o_pass; cap_cnt = o_cnt; cap_ffv = o_ffv;
        cap_ffop = o_ffop; cap_ffa = o_ffa; cap_ffb = o_ffb;
      end
      if (m_run) begin
        chk("run_busy", o_busy, 1);
        chk("run_done", o_done, int'(m_t == m_n + 3));
        if (m_t == m_n + 3) begin
          m_pass = int'(m_cnt == 0);
          chk_results("done");
          m_run = 0;
        end else if (m_t <= m_n && fault_i) begin
          m_k   = m_t - 1;
          m_per = 1 << (2 * m_w);
          m_op  = m_all ? m_k / m_per : m_mode;
          m_v   = m_k % m_per;
          if (m_cnt < (1 << (2 * m_w + 3)) - 1) m_cnt++;
          if (m_ffv == 0) begin
            m_ffv  = 1;
            m_ffop = m_op;
            m_ffa  = m_v >> m_w;
            m_ffb  = m_v & ((1 << m_w) - 1);
          end
        end
        m_t++;
      end else begin
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk_results("idle");
        if (start_i) begin
          m_run  = 1;
          m_t    = 1;
          m_mode = int'(mode_i);
          m_all  = (mode_i == 3'd7);
          m_w    = wsel ? 3 : 2;
          m_n    = (m_all ? 7 : 1) * (1 << (2 * m_w));
          m_cnt = 0; m_pass = 0; m_ffv = 0;
          m_ffop = 0; m_ffa = 0; m_ffb = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input bit sel);
    rst_n = 1'b0; start_i = 1'b0; fault_i = 1'b0;
    step();
    wsel = sel;
    step();
    rst_n = 1'b1;
    cyc = 0; done_n = 0; done_cyc = -1; first_done = -1;
    busy_n = 0; busy_first = -1;
  endtask

  initial begin
    // W=2 AND, clean
    do_reset(1'b0);
    mode_i = 3'd1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_to(21);
    chk("s1_done_cyc", done_cyc, 19);
    chk("s1_done_n", done_n, 1);
    chk("s1_pass", cap_pass, 1);
    chk("s1_cnt", cap_cnt, 0);
    chk("s1_ffv", cap_ffv, 0);
    chk("s1_busy_n", busy_n, 19);
    chk("s1_busy_first", busy_first, 1);

    // W=2 ALL, clean
    do_reset(1'b0);
    mode_i = 3'd7; start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_to(117);
    chk("s2_done_cyc", done_cyc, 115);
    chk("s2_pass", cap_pass, 1);
    chk("s2_cnt", cap_cnt, 0);
    chk("s2_busy_n", busy_n, 115);

    // W=2 XOR, fault held
    do_reset(1'b0);
    mode_i = 3'd3; start_i = 1'b1; fault_i = 1'b1;
    step();
    start_i = 1'b0;
    run_to(21);
    fault_i = 1'b0;
    chk("s3_done_cyc", done_cyc, 19);
    chk("s3_cnt", cap_cnt, 16);
    chk("s3_pass", cap_pass, 0);
    chk("s3_ffv", cap_ffv, 1);
    chk("s3_ffop", cap_ffop, 3);
    chk("s3_ffa", cap_ffa, 0);
    chk("s3_ffb", cap_ffb, 0);

    // W=2 OR, single fault in cycle 10
    do_reset(1'b0);
    mode_i = 3'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    while (cyc < 21) begin
      fault_i = (cyc == 10);
      step();
    end
    fault_i = 1'b0;
    chk("s4_cnt", cap_cnt, 1);
    chk("s4_pass", cap_pass, 0);
    chk("s4_ffop", cap_ffop, 2);
    chk("s4_ffa", cap_ffa, 2);
    chk("s4_ffb", cap_ffb, 1);

    // W=2 INV, start re-pulsed mid-sweep and in DONE
    do_reset(1'b0);
    mode_i = 3'd0; start_i = 1'b1; fault_i = 1'b1;
    step();
    while (cyc < 21) begin
      start_i = (cyc == 5 || cyc == 19 || cyc == 20);
      fault_i = (cyc < 19);
      if (cyc == 20) chk("s5_cnt_c20", o_cnt, 16);
      step();
    end
    start_i = 1'b0; fault_i = 1'b0;
    chk("s5_cnt_c21", o_cnt, 0);
    chk("s5_first_done", first_done, 19);
    chk("s5_done_n_a", done_n, 1);
    chk("s5_cnt1", cap_cnt, 16);
    run_to(41);
    chk("s5_done_n_b", done_n, 2);
    chk("s5_done_cyc", done_cyc, 39);
    chk("s5_pass", cap_pass, 1);

    // W=3 XNOR, reset mid-sweep then restart
    do_reset(1'b1);
    mode_i = 3'd6; start_i = 1'b1; fault_i = 1'b1;
    step();
    start_i = 1'b0;
    run_to(30);
    chk("s6_busy_pre", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", o_busy, 0);
    chk("s6_rst_done", o_done, 0);
    chk("s6_rst_cnt", o_cnt, 0);
    chk("s6_rst_ffv", o_ffv, 0);
    step();
    rst_n = 1'b1; fault_i = 1'b0;
    done_n = 0;
    run_to(40);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_to(110);
    chk("s6_done_cyc", done_cyc, 107);
    chk("s6_done_n", done_n, 1);
    chk("s6_pass", cap_pass, 1);
    chk("s6_cnt", cap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_gate_sweeper.md
# mux_gate_sweeper

Sequential, parametrised self-check engine for logic gates built only from 2:1 multiplexers. On a start request it sweeps every operand pair for one gate, or for all seven gates. Each vector's mux-built result is compared against a native-operator reference, failures are counted, and the first failing vector is captured. It sits in the gate-construction test area as a clocked, width-generic checker with a start/done handshake.

## Interface
- `W`, default 2: operand width in bits, legal 1..6.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start_i`  input  1  request a sweep; sampled only in IDLE.
- `mode_i`  input  3  gate select, sampled with `start_i`:
  - 0 INV(a), 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR.
  - 7 ALL: ops 0..6 in order.
- `fault_i`  input  1  fault injection; sampled per vector at issue.
- `busy_o`  output  1  high from the first SWEEP cycle through DONE.
- `done_o`  output  1  one-cycle pulse; sweep complete, results final.
- `pass_o`  output  1  valid from `done_o`, held until the next accepted start.
- `fail_cnt_o`  output  2W+3  count of failing vectors, saturating.
- `first_fail_vld_o`  output  1  a failure has been captured this sweep.
- `first_fail_op_o`  output  3  op of the first failing vector.
- `first_fail_a_o`  output  W  a of the first failing vector.
- `first_fail_b_o`  output  W  b of the first failing vector.

## Operation
- Vector index `i`: op-major. `a = i[2W-1:W]`, `b = i[W-1:0]`, both incrementing.
  - Single-gate modes: N = 2^(2W) vectors.
  - ALL mode: N = 7·2^(2W) vectors.
  - INV still sweeps b; b is a don't-care for INV.
- Actual result: per bit, built only from `mux2(d0,d1,sel) = sel ? d1 : d0`. No other logic operators on operand data.
  - INV = mux2(1,0,a); AND = mux2(0,a,b); OR = mux2(a,1,b).
  - XOR = mux2(a, INV(a), b); XNOR = mux2(INV(a), a, b).
  - NAND = INV(AND); NOR = INV(OR).
- Expected result: native operators (`~a`, `a&b`, …).
- A vector fails if any of its W bits differ.
- `fault_i`=1 at issue inverts bit 0 of that vector's actual result.
- FSM states: IDLE → SWEEP → DRAIN → DONE → IDLE.
  - IDLE → SWEEP: when `start_i`=1. Mode is latched; fail count, pass and capture registers are cleared.
  - SWEEP: issue one vector per cycle. Go to DRAIN after vector N-1 is issued.
  - DRAIN: exactly 2 cycles, to flush pipeline stages S1 (compute) and S2 (compare/accumulate).
  - DONE: 1 cycle; `done_o`=1; `pass_o` = (fail count == 0).
- `start_i` is ignored outside IDLE, including in DONE.
- `fail_cnt_o` increments by 1 per failing vector and saturates at all-ones. With width 2W+3 saturation is unreachable, but it is still required.
- First-fail capture loads only while `first_fail_vld_o`=0. Later failures do not overwrite it.

## Timing
- Reset (asynchronous, any state, including mid-sweep):
  - FSM goes to IDLE; the pipeline is flushed.
  - All outputs are 0: `busy_o`, `done_o`, `pass_o`, `fail_cnt_o`, and all `first_fail_*`.
- Let `start_i` be accepted in cycle 0.
  - Vector k is issued in cycle k+1.
  - S1 registers the expected/actual pair at the end of cycle k+1.
  - S2 updates the count and capture at the end of cycle k+2.
- DRAIN occupies cycles N+1 and N+2. DONE (`done_o`=1) is cycle N+3.
- `busy_o` is high for cycles 1..N+3 and low in cycle N+4.
- `fail_cnt_o` and `first_fail_*` are final by the start of cycle N+3. They change mid-sweep, so they are sampled only at `done_o`.
- Results hold in IDLE until the next accepted start clears them at the end of the acceptance cycle.
- `start_i` high in cycle N+3 is ignored. Held high in cycle N+4, it starts a new sweep.

## Test plan
- W=2, mode 1, fault_i=0:
  - `done_o` in cycle 19.
  - `pass_o`=1, `fail_cnt_o`=0, `first_fail_vld_o`=0.
  - `busy_o` high in cycles 1..19.
- W=2, mode 7, fault_i=0:
  - `done_o` in cycle 115.
  - `pass_o`=1, `fail_cnt_o`=0.
- W=2, mode 3, fault_i held at 1:
  - `fail_cnt_o`=16, `pass_o`=0.
  - First fail: op=3, a=0, b=0.
- W=2, mode 2, fault_i=1 only in cycle 10 (vector a=2, b=1):
  - `fail_cnt_o`=1.
  - First fail: op=2, a=2, b=1.
- W=2, mode 0, start_i re-pulsed in cycles 5 and 19:
  - Both pulses are ignored; `done_o` in cycle 19 only.
  - `start_i` in cycle 20 starts a new sweep; `fail_cnt_o` clears at the end of cycle 20.
- W=3, mode 6, rst_n low for one cycle at cycle 30, then start in cycle 40:
  - All outputs 0 immediately on reset; FSM in IDLE.
  - After the restart, `done_o` in cycle 40+67=107 and `pass_o`=1.
